// File: rtl/upsample_2x2_nearest.sv
`default_nettype none
// ============================================================================
//  Module   : upsample_2x2_nearest
//  Purpose  : 2x nearest-neighbour upsampler for a raster-order feature map.
//             Every input pixel is emitted twice on the even output row and
//             captured in a row buffer. The buffered row is then replayed,
//             each pixel twice, to form the odd output row.
//  Revision : 1.0 - initial release
// ============================================================================
module upsample_2x2_nearest #(
    parameter int DATA_WIDHT = 32,
    parameter int IMG_WIDHT  = 110,
    parameter int IMG_HEIGHT = 110
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDHT-1:0] Data_In,
    input  logic                  Valid_In,
    output logic                  Ready_In,
    output logic [DATA_WIDHT-1:0] Data_Out,
    output logic                  Valid_Out,
    input  logic                  Ready_Out,
    output logic                  Last_Out,
    output logic                  Frame_Done
);

    localparam int COL_W = $clog2(IMG_WIDHT);
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    localparam logic [COL_W-1:0] c_col_last = COL_W'(IMG_WIDHT - 1);
    localparam logic [ROW_W-1:0] c_row_last = ROW_W'(IMG_HEIGHT - 1);

    localparam logic [0:0] c_S_EVEN = 1'b0;
    localparam logic [0:0] c_S_ODD  = 1'b1;

    logic [0:0]            r_state;
    logic [COL_W-1:0]      r_col;
    logic [ROW_W-1:0]      r_row;
    logic                  r_phase;
    logic [DATA_WIDHT-1:0] r_data;
    logic                  r_valid;
    logic                  r_last;
    logic                  r_frame_done;
    logic [DATA_WIDHT-1:0] r_rowbuf [IMG_WIDHT];

    logic                  w_beat;
    logic                  w_accept;
    logic [COL_W-1:0]      w_col_next;
    logic [COL_W-1:0]      w_wr_col;
    logic [COL_W-1:0]      w_rd_col;

    // The output beat in flight transfers this cycle.
    assign w_beat     = r_valid & Ready_Out;
    assign w_col_next = r_col + 1'b1;

    // Input is taken only on the even row, when the output register is empty
    // or its second copy is leaving, and never once the row's last pixel is
    // already held (the next row must wait for the odd-row replay).
    assign Ready_In = rst
                    & (r_state == c_S_EVEN)
                    & ~(r_valid & (r_col == c_col_last))
                    & (~r_valid | (r_phase & Ready_Out));

    assign w_accept = Valid_In & Ready_In;

    // While a pixel is held, r_col names it, so a same-cycle accept lands one
    // slot further; with the register empty r_col already names the free slot.
    assign w_wr_col = r_valid ? w_col_next : r_col;

    // Odd row: the first read (register empty) fetches r_col, later reads
    // prefetch the next column during the current column's second beat.
    assign w_rd_col = r_valid ? w_col_next : r_col;

    // Row buffer capture of each accepted even-row pixel.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_rowbuf[w_wr_col] <= Data_In;
        end
    end

    // Control state machine and output register; all state holds under stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= c_S_EVEN;
            r_col        <= '0;
            r_row        <= '0;
            r_phase      <= 1'b0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_last       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                c_S_EVEN: begin
                    if (w_beat) begin
                        if (!r_phase) begin
                            r_phase <= 1'b1;
                        end else begin
                            r_phase <= 1'b0;
                            if (r_col == c_col_last) begin
                                r_col   <= '0;
                                r_valid <= 1'b0;
                                r_state <= c_S_ODD;
                            end else begin
                                r_col   <= w_col_next;
                                r_valid <= w_accept;
                                if (w_accept) begin
                                    r_data <= Data_In;
                                end
                            end
                        end
                    end else if (w_accept) begin
                        r_data  <= Data_In;
                        r_valid <= 1'b1;
                        r_phase <= 1'b0;
                    end
                end
                default: begin
                    if (!r_valid) begin
                        // Entry bubble: registered read of column 0.
                        r_data  <= r_rowbuf[w_rd_col];
                        r_valid <= 1'b1;
                        r_phase <= 1'b0;
                    end else if (Ready_Out) begin
                        if (!r_phase) begin
                            r_phase <= 1'b1;
                            if ((r_col == c_col_last) && (r_row == c_row_last)) begin
                                r_last <= 1'b1;
                            end
                        end else begin
                            r_phase <= 1'b0;
                            if (r_col == c_col_last) begin
                                r_col   <= '0;
                                r_valid <= 1'b0;
                                r_last  <= 1'b0;
                                r_state <= c_S_EVEN;
                                if (r_row == c_row_last) begin
                                    r_row        <= '0;
                                    r_frame_done <= 1'b1;
                                end else begin
                                    r_row <= r_row + 1'b1;
                                end
                            end else begin
                                r_col  <= w_col_next;
                                r_data <= r_rowbuf[w_rd_col];
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign Data_Out   = r_data;
    assign Valid_Out  = r_valid;
    assign Last_Out   = r_last;
    assign Frame_Done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_upsample_2x2_nearest.sv
`default_nettype none
// ============================================================================
//  Module   : tb_upsample_2x2_nearest
//  Purpose  : Self-checking bench for upsample_2x2_nearest (4x2 input frame).
//             Scenario table plus hand-written reset-abort sequence; output
//             beats are checked against a scoreboard fed at input acceptance.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_upsample_2x2_nearest;

    localparam int DW = 32;
    localparam int W  = 4;
    localparam int H  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] Data_In;
    logic          Valid_In;
    logic          Ready_In;
    logic [DW-1:0] Data_Out;
    logic          Valid_Out;
    logic          Ready_Out;
    logic          Last_Out;
    logic          Frame_Done;

    always #5 clk = ~clk;

    upsample_2x2_nearest #(
        .DATA_WIDHT (DW),
        .IMG_WIDHT  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .Data_In    (Data_In),
        .Valid_In   (Valid_In),
        .Ready_In   (Ready_In),
        .Data_Out   (Data_Out),
        .Valid_Out  (Valid_Out),
        .Ready_Out  (Ready_Out),
        .Last_Out   (Last_Out),
        .Frame_Done (Frame_Done)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic          odd;
    } beat_t;

    typedef struct {
        logic [DW-1:0] first_pix;
        int            frames;
        int            pct;
        bit            dead;
        int            exp_beats;
        logic [DW-1:0] exp_first;
        logic [DW-1:0] exp_lastd;
        int            exp_fd;
    } scen_t;

    beat_t         exp_q[$];
    logic [DW-1:0] src_q[$];
    logic [DW-1:0] mbuf[$];
    int            mrow = 0;

    int n_chk  = 0;
    int n_fail = 0;

    int ready_pct = 100;
    bit dead      = 1'b0;

    int            beats_seen, fd_seen, last_seen, gap_run, max_gap;
    logic [DW-1:0] first_data, last_data;
    bit            stall_prev = 1'b0;
    logic [DW-1:0] stall_data;
    logic          stall_last;
    bit            fd_exp = 1'b0;

    task automatic check_word(string name, logic [DW-1:0] act, logic [DW-1:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic check_bit(string name, logic act, logic req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, req);
        end
    endtask

    task automatic check_int(string name, int act, int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Reference model: two copies now, full odd-row replay after the row's last pixel.
    function automatic void model_accept(logic [DW-1:0] d);
        beat_t b;
        mbuf.push_back(d);
        b.data = d;
        b.last = 1'b0;
        b.odd  = 1'b0;
        exp_q.push_back(b);
        exp_q.push_back(b);
        if (mbuf.size() == W) begin
            for (int c = 0; c < W; c++) begin
                for (int k = 0; k < 2; k++) begin
                    b.data = mbuf[c];
                    b.odd  = 1'b1;
                    b.last = (mrow == H - 1) && (c == W - 1) && (k == 1);
                    exp_q.push_back(b);
                end
            end
            mbuf.delete();
            mrow = (mrow == H - 1) ? 0 : mrow + 1;
        end
    endfunction

    // Driver: inputs and Ready_Out change 1 time unit after each rising edge.
    initial begin
        Valid_In  = 1'b0;
        Data_In   = '0;
        Ready_Out = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            Ready_Out = (int'($urandom_range(99)) < ready_pct);
            if (src_q.size() > 0) begin
                Valid_In = 1'b1;
                Data_In  = src_q[0];
            end else if (dead) begin
                Valid_In = 1'b1;
                Data_In  = 32'h0000_DEAD;
            end else begin
                Valid_In = 1'b0;
                Data_In  = '0;
            end
        end
    end

    // Monitor: everything sampled on the falling edge.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check_bit("reset_valid_out", Valid_Out, 1'b0);
                check_bit("reset_ready_in", Ready_In, 1'b0);
                check_bit("reset_last_out", Last_Out, 1'b0);
                check_bit("reset_frame_done", Frame_Done, 1'b0);
                check_word("reset_data_out", Data_Out, '0);
                stall_prev = 1'b0;
                fd_exp     = 1'b0;
                gap_run    = 0;
            end else begin
                check_bit("frame_done", Frame_Done, fd_exp);
                if (Frame_Done) fd_seen++;
                fd_exp = 1'b0;

                if (stall_prev) begin
                    check_bit("stall_valid_hold", Valid_Out, 1'b1);
                    check_word("stall_data_hold", Data_Out, stall_data);
                    check_bit("stall_last_hold", Last_Out, stall_last);
                end

                if (Valid_Out && exp_q.size() > 0 && exp_q[0].odd) begin
                    check_bit("ready_in_low_odd_row", Ready_In, 1'b0);
                end

                if (Valid_Out && Ready_Out) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_beat: got %0h, expected no beat", Data_Out);
                    end else begin
                        e = exp_q.pop_front();
                        check_word("beat_data", Data_Out, e.data);
                        check_bit("beat_last", Last_Out, e.last);
                        fd_exp = e.last;
                    end
                    beats_seen++;
                    if (beats_seen == 1) first_data = Data_Out;
                    if (Last_Out) begin
                        last_seen++;
                        last_data = Data_Out;
                    end
                end

                stall_prev = Valid_Out && !Ready_Out;
                stall_data = Data_Out;
                stall_last = Last_Out;

                if (Valid_Out) begin
                    gap_run = 0;
                end else if (beats_seen > 0 && (src_q.size() > 0 || exp_q.size() > 0)) begin
                    gap_run++;
                    if (gap_run > max_gap) max_gap = gap_run;
                end

                if (Valid_In && Ready_In) begin
                    if (src_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_accept: got %0h, expected no accept", Data_In);
                    end else begin
                        model_accept(src_q.pop_front());
                    end
                end

                if (dead && src_q.size() == 0 && exp_q.size() == 0) dead = 1'b0;
            end
        end
    end

    task automatic clear_stats();
        beats_seen = 0;
        fd_seen    = 0;
        last_seen  = 0;
        gap_run    = 0;
        max_gap    = 0;
        first_data = '0;
        last_data  = '0;
    endtask

    task automatic wait_drain(int max_cyc);
        bit done;
        done = 1'b0;
        for (int k = 0; k < max_cyc && !done; k++) begin
            @(negedge clk);
            #1;
            done = (src_q.size() == 0) && (exp_q.size() == 0) && !fd_exp;
        end
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d beats pending, expected 0", exp_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        scen_t tbl[4];
        bit    emptied;

        //             first  frm pct dead beats first lastd fd
        tbl[0] = '{32'd1,  1, 100, 1'b0, 32, 32'd1,  32'd8,  1};
        tbl[1] = '{32'd1,  1,  50, 1'b0, 32, 32'd1,  32'd8,  1};
        tbl[2] = '{32'd1,  2, 100, 1'b0, 64, 32'd1,  32'd16, 2};
        tbl[3] = '{32'd21, 1,  30, 1'b1, 32, 32'd21, 32'd28, 1};

        rst = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;

        for (int i = 0; i < 4; i++) begin
            clear_stats();
            ready_pct = tbl[i].pct;
            dead      = tbl[i].dead;
            for (int p = 0; p < W * H * tbl[i].frames; p++) begin
                src_q.push_back(tbl[i].first_pix + DW'(p));
            end
            wait_drain(3000);
            check_int("scen_beats", beats_seen, tbl[i].exp_beats);
            check_word("scen_first_beat", first_data, tbl[i].exp_first);
            check_word("scen_last_beat", last_data, tbl[i].exp_lastd);
            check_int("scen_frame_done_count", fd_seen, tbl[i].exp_fd);
            check_int("scen_last_count", last_seen, tbl[i].exp_fd);
            if (tbl[i].pct == 100) begin
                check_bit("scen_max_gap_le_1", max_gap <= 1, 1'b1);
            end
        end

        // Reset mid-frame after three pixels, then a fresh frame 9..16.
        ready_pct = 100;
        dead      = 1'b0;
        for (int p = 1; p <= 3; p++) src_q.push_back(DW'(p));
        emptied = 1'b0;
        for (int k = 0; k < 200 && !emptied; k++) begin
            @(negedge clk);
            #1;
            emptied = (src_q.size() == 0);
        end
        check_bit("pre_reset_inputs_taken", emptied, 1'b1);
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        src_q.delete();
        exp_q.delete();
        mbuf.delete();
        mrow = 0;
        @(posedge clk);
        #2 rst = 1'b1;
        clear_stats();
        for (int p = 9; p <= 16; p++) src_q.push_back(DW'(p));
        wait_drain(3000);
        check_int("post_reset_beats", beats_seen, 32);
        check_word("post_reset_first_beat", first_data, 32'd9);
        check_word("post_reset_last_beat", last_data, 32'd16);
        check_int("post_reset_frame_done_count", fd_seen, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/upsample_2x2_nearest.md
Name: upsample_2x2_nearest

Overview:
- Inverse of the 2x2 stride-2 max-pool window stage: expands a pooled raster-order feature map IMG_WIDHT x IMG_HEIGHT into 2*IMG_WIDHT x 2*IMG_HEIGHT by nearest-neighbour replication.
- Sits in the decoder/upsample path of the CNN pipeline between a pooled-feature producer and the next convolution's line buffers.
- Each input pixel is emitted twice on the even output row. The stored row is replayed, each pixel twice, on the odd output row.
- Valid/ready handshake on both sides; the stored row is held in an internal row buffer of IMG_WIDHT entries.

Parameters:
- DATA_WIDHT, 32, pixel word width in bits.
- IMG_WIDHT, 110, input (pooled) image width in pixels; must be >= 2.
- IMG_HEIGHT, 110, input image height in rows; must be >= 1.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- Data_In  input  DATA_WIDHT  input pixel, raster order.
- Valid_In  input  1  Data_In valid.
- Ready_In  output  1  block can accept Data_In; a transfer occurs when Valid_In && Ready_In.
- Data_Out  output  DATA_WIDHT  output pixel, raster order of the 2x-upsampled image.
- Valid_Out  output  1  Data_Out valid.
- Ready_Out  input  1  downstream accepts; a beat transfers when Valid_Out && Ready_Out.
- Last_Out  output  1  high with the final beat of the output frame, at (2*IMG_HEIGHT-1, 2*IMG_WIDHT-1).
- Frame_Done  output  1  one-cycle pulse on the cycle after the final beat transfers.

Behaviour:
- Reset (rst low, asynchronous):
  - Valid_Out=0, Last_Out=0, Frame_Done=0, Data_Out=0.
  - State=S_EVEN; col, row and phase counters cleared.
  - Ready_In is forced 0 while rst is low.
  - Row buffer contents are don't-care.
- Output register: Data_Out, Valid_Out and Last_Out are registered. The phase bit selects the first (0) or second (1) copy of the current pixel.
- Data_Out and Valid_Out must hold stable while Valid_Out && !Ready_Out (AXI-style; no retraction).
- S_EVEN (even output row, input row r):
  - Ready_In = !Valid_Out || (phase==1 && Ready_Out). This is a combinational path from Ready_Out.
  - On input transfer at cycle t: rowbuf[col] <= Data_In; Data_Out <= Data_In; Valid_Out=1 at t+1; phase=0.
  - On a transfer with phase 0: Data_Out is held, phase <= 1.
  - On a transfer with phase 1: phase <= 0, col++. Valid_Out drops unless a new input is accepted in the same cycle.
  - Steady-state throughput is 1 input per 2 cycles with Ready_Out=1.
  - When the phase-1 beat of col=IMG_WIDHT-1 transfers: col <= 0, state <= S_ODD.
- S_ODD (odd output row):
  - Ready_In=0.
  - rowbuf has a registered read with 1-cycle latency. The read of col+1 is issued during the phase-1 beat of col.
  - Exactly one bubble cycle (Valid_Out=0) is allowed at S_ODD entry. After that, 2*IMG_WIDHT consecutive beats are produced when Ready_Out is held 1.
  - Each entry is emitted twice, using the same phase rules as S_EVEN.
  - After the phase-1 beat of col=IMG_WIDHT-1:
    - If row < IMG_HEIGHT-1: row++, state <= S_EVEN.
    - Else: row <= 0, state <= S_EVEN, Frame_Done pulses on the next cycle.
- Last_Out is high only on the S_ODD, row=IMG_HEIGHT-1, col=IMG_WIDHT-1, phase=1 beat. It is held with Data_Out under stall.
- Backpressure: Ready_Out low for any duration freezes all state and outputs. No beat is lost or duplicated beyond the defined 2x replication.
- Counters: col is $clog2(IMG_WIDHT) bits and row is $clog2(IMG_HEIGHT) bits. Each wraps only at its terminal value, never by overflow.
- Reset mid-frame aborts immediately. The first input after release is treated as pixel (0,0) of a new frame.
- Valid_In asserted while Ready_In=0 is ignored. Data_In is not sampled in that case.

Test Plan:
1. IMG_WIDHT=4, IMG_HEIGHT=2, inputs 1..8 streamed with Ready_Out=1 -> output rows 1,1,2,2,3,3,4,4 / 1,1,2,2,3,3,4,4 / 5,5,6,6,7,7,8,8 / 5,5,6,6,7,7,8,8.
   - 32 beats in total; Last_Out only on the 32nd beat (value 8); Frame_Done pulses exactly once, one cycle later.
2. Same stream with Ready_Out toggling pseudo-randomly (50%) -> identical 32-beat sequence.
   - Data_Out stable on every stalled cycle; Ready_In never high in S_ODD.
3. Throughput: Valid_In=1 and Ready_Out=1 continuously -> Ready_In high every other cycle in S_EVEN.
   - At most 1 bubble cycle at each S_ODD entry; no other Valid_Out gaps.
4. rst pulsed low after input pixel 3 of frame 1, then frame 9..16 sent -> Valid_Out=0 and Ready_In=0 during reset.
   - Output afterwards is 9,9,10,10,... with no residue of 1..3.
5. Two back-to-back frames (1..8 then 9..16) -> second frame output starts with 9,9 immediately after Frame_Done.
   - Frame_Done pulses twice; Last_Out twice.
6. Valid_In held 1 with Data_In=0xDEAD during S_ODD -> 0xDEAD never appears in the output; the odd row replays the stored values.
